// File: rtl/fetch_queue.sv
// fetch_queue: decoupling instruction queue between instruction fetch and a
// 2-wide decoder. One packet in per cycle, the two oldest entries presented
// in parallel, zero/one/two consumed per cycle, single-cycle flush.
// Packet layout: pc[64:33], data[32:1], taken_branch[0].
// DEPTH must be a power of two and at least 4 so that the pointers wrap
// naturally and head+1 never aliases head.
module fetch_queue #(
    parameter int DEPTH    = 8,
    parameter int PACKET_W = 65,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push_valid,
    input  logic [PACKET_W-1:0] push_data,
    output logic                push_ready,
    output logic                out_valid_1,
    output logic [PACKET_W-1:0] out_data_1,
    output logic                out_valid_2,
    output logic [PACKET_W-1:0] out_data_2,
    input  logic                pop_1,
    input  logic                pop_2,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Packet storage is deliberately not reset: validity comes from r_count.
    logic [PACKET_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic                w_ready;
    logic                w_valid_1;
    logic                w_valid_2;
    logic                w_push_eff;
    logic                w_pop1_eff;
    logic                w_pop2_eff;
    logic [PTR_W-1:0]    w_head_p1;
    logic [PTR_W-1:0]    w_head_nxt;
    logic [PTR_W-1:0]    w_tail_nxt;
    logic [CNT_W-1:0]    w_count_nxt;

    // Occupancy-derived status; readiness uses only the registered count so
    // there is no combinational path from the decoder pops to push_ready.
    always_comb begin
        w_ready   = (r_count < CNT_W'(DEPTH));
        w_valid_1 = (r_count >= CNT_W'(1));
        w_valid_2 = (r_count >= CNT_W'(2));
    end

    // Effective handshake qualification: pop_2 only counts together with
    // pop_1 so entries always leave in order; flush cancels a push.
    always_comb begin
        w_push_eff = push_valid && w_ready && !flush;
        w_pop1_eff = pop_1 && w_valid_1;
        w_pop2_eff = pop_2 && pop_1 && w_valid_2;
    end

    // Next-state pointer and count arithmetic (pointers wrap modulo DEPTH).
    always_comb begin
        w_head_p1   = r_head + PTR_W'(1);
        w_head_nxt  = r_head + PTR_W'(w_pop1_eff) + PTR_W'(w_pop2_eff);
        w_tail_nxt  = r_tail + PTR_W'(w_push_eff);
        w_count_nxt = r_count + CNT_W'(w_push_eff)
                              - CNT_W'(w_pop1_eff)
                              - CNT_W'(w_pop2_eff);
    end

    // Pointer and occupancy registers; flush outranks any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Storage write at the tail slot for every accepted packet.
    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_mem[r_tail] <= push_data;
        end
    end

    // Read side: the two oldest entries, zeroed when not valid. No bypass,
    // so a packet becomes visible the cycle after it is written.
    always_comb begin
        out_data_1 = '0;
        out_data_2 = '0;
        if (w_valid_1) begin
            out_data_1 = r_mem[r_head];
        end else begin
            out_data_1 = '0;
        end
        if (w_valid_2) begin
            out_data_2 = r_mem[w_head_p1];
        end else begin
            out_data_2 = '0;
        end
    end

    assign push_ready  = w_ready;
    assign out_valid_1 = w_valid_1;
    assign out_valid_2 = w_valid_2;
    assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue plus hand-written sequences
// for asynchronous reset and continuous streaming.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic [64:0] push_data;
    logic        push_ready;
    logic        out_valid_1;
    logic [64:0] out_data_1;
    logic        out_valid_2;
    logic [64:0] out_data_2;
    logic        pop_1;
    logic        pop_2;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(8), .PACKET_W(65)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .out_valid_1(out_valid_1),
        .out_data_1 (out_data_1),
        .out_valid_2(out_valid_2),
        .out_data_2 (out_data_2),
        .pop_1      (pop_1),
        .pop_2      (pop_2),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        pv;
        logic [31:0] pc;
        logic        p1;
        logic        p2;
        logic [3:0]  cnt;
        logic        rdy;
        logic        v1;
        logic [31:0] pc1;
        logic        v2;
        logic [31:0] pc2;
    } vec_t;

    vec_t vecs[$];

    // Packet encoding: data is ~pc, taken_branch set only for pc 0x208.
    function automatic logic [64:0] mk(input logic [31:0] pc);
        return {pc, ~pc, (pc == 32'h0000_0208)};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic pv, input logic [31:0] pc,
                       input logic p1, input logic p2, input logic [3:0] cnt,
                       input logic rdy, input logic v1, input logic [31:0] pc1,
                       input logic v2, input logic [31:0] pc2);
        vec_t v;
        v.fl = fl; v.pv = pv; v.pc = pc; v.p1 = p1; v.p2 = p2;
        v.cnt = cnt; v.rdy = rdy; v.v1 = v1; v.pc1 = pc1; v.v2 = v2; v.pc2 = pc2;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_1 = 1'b0; pop_2 = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic rdy,
                             input logic v1, input logic [31:0] pc1,
                             input logic v2, input logic [31:0] pc2);
        chk({tag, ".count"}, 65'(count), 65'(cnt));
        chk({tag, ".push_ready"}, 65'(push_ready), 65'(rdy));
        chk({tag, ".out_valid_1"}, 65'(out_valid_1), 65'(v1));
        chk({tag, ".out_data_1"}, out_data_1, v1 ? mk(pc1) : 65'd0);
        chk({tag, ".out_valid_2"}, 65'(out_valid_2), 65'(v2));
        chk({tag, ".out_data_2"}, out_data_2, v2 ? mk(pc2) : 65'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_state("reset", 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_state("idle", 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // ---------------- vector table (expected = state after the edge) ----
        // Fill 0x100..0x11C with no pops.
        for (int i = 0; i < 8; i++)
            add(1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 4'(i + 1), (i + 1) < 8,
                1'b1, 32'h100, i >= 1, 32'h104);
        // 9th push while full is held off.
        add(1'b0, 1'b1, 32'h120, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 32'h100, 1'b1, 32'h104);
        // Dual pops drain the queue in pairs.
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 32'h108, 1'b1, 32'h10C);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 32'h110, 1'b1, 32'h114);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 32'h118, 1'b1, 32'h11C);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
        // Push 7 (slots 0..6), tail ends at 7.
        for (int i = 0; i < 7; i++)
            add(1'b0, 1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 4'(i + 1), 1'b1,
                1'b1, 32'h300, i >= 1, 32'h304);
        // Pop pairs: head goes 2, 4, 6.
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 32'h308, 1'b1, 32'h30C);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 32'h310, 1'b1, 32'h314);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 32'h318, 1'b0, 32'h0);
        // Push into slot 7 with a pop: head = 7.
        add(1'b0, 1'b1, 32'h31C, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 32'h31C, 1'b0, 32'h0);
        // Push into slot 0: out_data_2 read from wrapped index 0.
        add(1'b0, 1'b1, 32'h320, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h31C, 1'b1, 32'h320);
        // Push + pop pair across the wrap.
        add(1'b0, 1'b1, 32'h324, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 32'h324, 1'b0, 32'h0);
        // count=1 with both pops: only one consumed.
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        // Build count=3, then pop_2 alone is ignored.
        add(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
        add(1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 32'h400, 1'b1, 32'h404);
        add(1'b0, 1'b1, 32'h408, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 32'h400, 1'b1, 32'h404);
        add(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 32'h400, 1'b1, 32'h404);
        add(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 32'h404, 1'b1, 32'h408);
        // Grow to 5, then flush with a same-cycle push and pop.
        add(1'b0, 1'b1, 32'h40C, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 32'h404, 1'b1, 32'h408);
        add(1'b0, 1'b1, 32'h410, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 32'h404, 1'b1, 32'h408);
        add(1'b0, 1'b1, 32'h414, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 32'h404, 1'b1, 32'h408);
        add(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        // The flushed 0x200 never shows up.
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        foreach (vecs[k]) begin
            @(negedge clk);
            flush      = vecs[k].fl;
            push_valid = vecs[k].pv;
            push_data  = mk(vecs[k].pc);
            pop_1      = vecs[k].p1;
            pop_2      = vecs[k].p2;
            @(posedge clk); #1;
            chk_state($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].rdy, vecs[k].v1,
                      vecs[k].pc1, vecs[k].v2, vecs[k].pc2);
        end

        // ---------------- steady streaming ----------------
        @(negedge clk);
        idle_inputs();
        push_valid = 1'b1;
        push_data  = mk(32'h1F0);
        @(posedge clk); #1;
        chk("stream.prime_count", 65'(count), 65'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            push_valid = 1'b1;
            push_data  = mk(32'h1F4 + 32'(4 * k));
            pop_1      = 1'b1;
            pop_2      = 1'b0;
            chk($sformatf("stream%0d.out_data_1", k), out_data_1, mk(32'h1F0 + 32'(4 * k)));
            if (k == 6) chk("stream.taken_branch", 65'(out_data_1[0]), 65'd1);
            else        chk($sformatf("stream%0d.taken_branch", k), 65'(out_data_1[0]), 65'd0);
            @(posedge clk); #1;
            chk($sformatf("stream%0d.count", k), 65'(count), 65'd1);
            chk($sformatf("stream%0d.push_ready", k), 65'(push_ready), 65'd1);
        end

        // ---------------- async reset mid-stream with 5 entries ----------------
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            push_valid = 1'b1;
            push_data  = mk(32'h500 + 32'(4 * k));
            @(posedge clk); #1;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("prereset.count", 65'(count), 65'd5);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_reset", 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_state("after_reset", 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
